// File: rtl/res_packer.sv
// rtl/res_packer.sv - scale, saturate and pack core results into buffered wide words
//
// Purpose: normalises each RES_W-bit result from core to an 8-bit pixel
// (right shift by SHIFT, saturate at 0xFF) and packs PACK pixels per output
// word. Completed words go through a FIFO_DEPTH-entry show-ahead FIFO with a
// valid/ready drain. core cannot be stalled, so a word completed while the
// FIFO is full (and not popping) is dropped and o_overflow is set (sticky).
//
// Optional feature: define RES_PACKER_ROUND_EN to round half up before the
// shift instead of truncating.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_res, i_valid   result stream from core
//   i_last           end of row, qualified by i_valid
//   o_data, o_keep   packed pixels (lane 0 in [7:0]) and lane-valid mask
//   o_last           word holds the row's last pixel
//   o_valid, i_ready FIFO head handshake
//   o_overflow       sticky: a completed word was dropped
module res_packer #(
  parameter int RES_W      = 18,
  parameter int SHIFT      = 4,
  parameter int PACK       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [RES_W-1:0]    i_res,
  input  logic                i_valid,
  input  logic                i_last,
  output logic [PACK*8-1:0]   o_data,
  output logic [PACK-1:0]     o_keep,
  output logic                o_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_overflow
);

  localparam int CNT_W = $clog2(PACK);
  localparam int AW    = $clog2(FIFO_DEPTH);

  // Stage 1: scale and saturate
  logic [RES_W:0] sum;
  logic [RES_W:0] scaled;
  logic [7:0]     sat_byte;

`ifdef RES_PACKER_ROUND_EN
  // (2**SHIFT)/2 is half an LSB of the result, and 0 when SHIFT is 0
  localparam logic [RES_W:0] RND = (RES_W+1)'((2**SHIFT) / 2);
  assign sum = {1'b0, i_res} + RND;
`else
  assign sum = {1'b0, i_res};
`endif

  assign scaled   = sum >> SHIFT;
  assign sat_byte = (|scaled[RES_W:8]) ? 8'hFF : scaled[7:0];

  logic       s1_valid;
  logic       s1_last;
  logic [7:0] s1_byte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_byte  <= 8'h00;
    end else begin
      s1_valid <= i_valid;
      s1_last  <= i_valid & i_last;
      if (i_valid) s1_byte <= sat_byte;
    end
  end

  // Stage 2: pack
  logic [PACK*8-1:0] pack_data;
  logic [PACK-1:0]   pack_keep;
  logic [CNT_W-1:0]  cnt;
  logic [PACK*8-1:0] word_next;
  logic [PACK-1:0]   keep_next;
  logic              push;

  always_comb begin
    word_next = pack_data;
    keep_next = pack_keep;
    word_next[8*int'(cnt) +: 8] = s1_byte;
    keep_next[cnt]              = 1'b1;
    push = s1_valid && ((cnt == CNT_W'(PACK-1)) || s1_last);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pack_data <= '0;
      pack_keep <= '0;
      cnt       <= '0;
    end else if (s1_valid) begin
      if (push) begin
        // completed word leaves for the FIFO (or is dropped); restart at lane 0
        pack_data <= '0;
        pack_keep <= '0;
        cnt       <= '0;
      end else begin
        pack_data <= word_next;
        pack_keep <= keep_next;
        cnt       <= cnt + 1'b1;
      end
    end
  end

  // Output FIFO (show-ahead)
  logic [PACK*8-1:0] mem_data [FIFO_DEPTH];
  logic [PACK-1:0]   mem_keep [FIFO_DEPTH];
  logic              mem_last [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic [PACK*8-1:0] hold_data;
  logic [PACK-1:0]   hold_keep;
  logic              hold_last;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign o_valid = (count != '0);
  assign pop     = o_valid && i_ready;
  // a pop frees the head slot at the same edge, so full+push+pop still stores
  assign wr_en   = push && (!full || pop);

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= word_next;
      mem_keep[wr_ptr] <= keep_next;
      mem_last[wr_ptr] <= s1_last;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
      hold_data  <= '0;
      hold_keep  <= '0;
      hold_last  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_data <= mem_data[rd_ptr];
        hold_keep <= mem_keep[rd_ptr];
        hold_last <= mem_last[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) o_overflow <= 1'b1;
    end
  end

  // When empty the outputs keep showing the last word handed out
  assign o_data = o_valid ? mem_data[rd_ptr] : hold_data;
  assign o_keep = o_valid ? mem_keep[rd_ptr] : hold_keep;
  assign o_last = o_valid ? mem_last[rd_ptr] : hold_last;

endmodule

// File: tb/tb_res_packer.sv
// tb/tb_res_packer.sv - scoreboard bench for res_packer
module tb_res_packer;

  localparam int RES_W      = 18;
  localparam int SHIFT      = 4;
  localparam int PACK       = 8;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              rst_n;
  logic [RES_W-1:0]  i_res;
  logic              i_valid;
  logic              i_last;
  logic [PACK*8-1:0] o_data;
  logic [PACK-1:0]   o_keep;
  logic              o_last;
  logic              o_valid;
  logic              i_ready;
  logic              o_overflow;

  res_packer #(.RES_W(RES_W), .SHIFT(SHIFT), .PACK(PACK), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_res(i_res), .i_valid(i_valid), .i_last(i_last),
    .o_data(o_data), .o_keep(o_keep), .o_last(o_last), .o_valid(o_valid),
    .i_ready(i_ready), .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel value from plain integer arithmetic
  function automatic int scale(input int r);
    int rnd;
    int v;
    rnd = 0;
`ifdef RES_PACKER_ROUND_EN
    if (SHIFT > 0) rnd = 1 << (SHIFT - 1);
`endif
    v = (r + rnd) >> SHIFT;
    return (v > 255) ? 255 : v;
  endfunction

  // Model packing state and the word it completed at the last sampling edge
  int                m_lane = 0;
  logic [PACK*8-1:0] m_data = '0;
  logic [PACK-1:0]   m_keep = '0;
  bit                pend = 0;
  logic [PACK*8-1:0] pend_data;
  logic [PACK-1:0]   pend_keep;
  bit                pend_last;

  // Scoreboard: words expected in the DUT FIFO, oldest first
  logic [PACK*8-1:0] q_data [$];
  logic [PACK-1:0]   q_keep [$];
  bit                q_last [$];
  bit                exp_ovf = 0;
  int                pop_count = 0;
  logic [PACK*8-1:0] last_data;
  logic [PACK-1:0]   last_keep;
  logic              last_last;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_lane = 0; m_data = '0; m_keep = '0; pend = 0;
      end else if (i_valid) begin
        m_data[8*m_lane +: 8] = 8'(scale(int'(i_res)));
        m_keep[m_lane] = 1'b1;
        if (m_lane == PACK-1 || i_last) begin
          pend = 1; pend_data = m_data; pend_keep = m_keep; pend_last = i_last;
          m_lane = 0; m_data = '0; m_keep = '0;
        end else begin
          m_lane++;
        end
      end
    end
  end

  initial begin
    int  size_before;
    bit  popped;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_data.delete(); q_keep.delete(); q_last.delete();
        exp_ovf = 0; pend = 0;
      end else begin
        size_before = q_data.size();
        check("o_valid", 64'(o_valid), 64'(size_before != 0));
        check("o_overflow", 64'(o_overflow), 64'(exp_ovf));
        popped = 0;
        if (o_valid && i_ready && size_before != 0) begin
          check("o_data", o_data, q_data[0]);
          check("o_keep", 64'(o_keep), 64'(q_keep[0]));
          check("o_last", 64'(o_last), 64'(q_last[0]));
          last_data = o_data; last_keep = o_keep; last_last = o_last;
          void'(q_data.pop_front()); void'(q_keep.pop_front()); void'(q_last.pop_front());
          pop_count++;
          popped = 1;
        end
        if (pend) begin
          if (size_before == FIFO_DEPTH && !popped) begin
            exp_ovf = 1;
          end else begin
            q_data.push_back(pend_data); q_keep.push_back(pend_keep); q_last.push_back(pend_last);
          end
          pend = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [RES_W-1:0] r, input logic l);
    i_valid = 1'b1; i_res = r; i_last = l;
    tick(1);
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_pops(input string name, input int target);
    int n;
    n = 0;
    while (pop_count < target && n < 50) begin
      tick(1);
      n++;
    end
    check(name, 64'(pop_count), 64'(target));
  endtask

  initial begin
    int p0;
    logic [63:0] exp_round;
    rst_n = 1'b0; i_res = '0; i_valid = 1'b0; i_last = 1'b0; i_ready = 1'b1;
    #2;
    check("reset o_data", o_data, 64'h0);
    check("reset o_keep", 64'(o_keep), 64'h0);
    check("reset o_last", 64'(o_last), 64'h0);
    check("reset o_valid", 64'(o_valid), 64'h0);
    check("reset o_overflow", 64'(o_overflow), 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // basic pack
    p0 = pop_count;
    for (int i = 1; i <= 8; i++) send(RES_W'(i * 16), 1'b0);
    wait_pops("basic pop", p0 + 1);
    check("basic data", last_data, 64'h0807060504030201);
    check("basic keep", 64'(last_keep), 64'hFF);
    check("basic last", 64'(last_last), 64'h0);

    // saturation
    p0 = pop_count;
    send(18'h00FF0, 1'b0); send(18'h01000, 1'b0); send(18'h3FFFF, 1'b0);
    for (int i = 0; i < 5; i++) send('0, 1'b0);
    wait_pops("sat pop", p0 + 1);
    check("sat data", last_data, 64'h0000000000FFFFFF);

    // rounding
    p0 = pop_count;
    send(18'h018, 1'b0); send(18'h017, 1'b0);
    for (int i = 0; i < 6; i++) send('0, 1'b0);
    wait_pops("round pop", p0 + 1);
`ifdef RES_PACKER_ROUND_EN
    exp_round = 64'h0102;
`else
    exp_round = 64'h0101;
`endif
    check("round data", last_data, exp_round);

    // partial row, then a full word starting at lane 0
    p0 = pop_count;
    send(18'h010, 1'b0); send(18'h020, 1'b0); send(18'h030, 1'b1);
    wait_pops("partial pop", p0 + 1);
    check("partial data", last_data, 64'h030201);
    check("partial keep", 64'(last_keep), 64'h07);
    check("partial last", 64'(last_last), 64'h1);
    for (int i = 1; i <= 8; i++) send(RES_W'(i * 16), 1'b0);
    wait_pops("after partial pop", p0 + 2);
    check("after partial data", last_data, 64'h0807060504030201);

    // backpressure and overflow
    i_ready = 1'b0;
    p0 = pop_count;
    for (int i = 0; i < 40; i++) send(RES_W'($urandom_range(0, 4095)), 1'b0);
    tick(3);
    check("ovf flag", 64'(o_overflow), 64'h1);
    check("ovf no pops", 64'(pop_count), 64'(p0));
    i_ready = 1'b1;
    tick(6);
    check("ovf drained", 64'(pop_count), 64'(p0 + 4));

    // asynchronous reset mid-operation: 2 words buffered, 3 bytes packed
    i_ready = 1'b0;
    for (int i = 0; i < 19; i++) send(RES_W'($urandom_range(0, 4095)), 1'b0);
    tick(2);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst o_data", o_data, 64'h0);
    check("rst o_keep", 64'(o_keep), 64'h0);
    check("rst o_last", 64'(o_last), 64'h0);
    check("rst o_valid", 64'(o_valid), 64'h0);
    check("rst o_overflow", 64'(o_overflow), 64'h0);
    tick(2);
    rst_n = 1'b1;
    i_ready = 1'b1;
    p0 = pop_count;
    for (int i = 0; i < 8; i++) send(RES_W'($urandom_range(0, 4095)), 1'b0);
    tick(6);
    check("post rst words", 64'(pop_count), 64'(p0 + 1));
    check("post rst keep", 64'(last_keep), 64'hFF);

    // randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0)
        send(RES_W'($urandom_range(0, 18'h3FFFF) >> $urandom_range(0, 10)), ($urandom_range(0, 7) == 0));
      else
        tick(1);
    end
    i_ready = 1'b1;
    tick(20);
    check("drained", 64'(q_data.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
